// File: rtl/md_unit_pkg.sv
// Shared opcode and state encodings for the multiply/divide unit.
// Opcode values must stay aligned with the ones the decoder emits on E_MDOp.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMthi  = 4'd5,
    MdMtlo  = 4'd6,
    MdMfhi  = 4'd7,
    MdMflo  = 4'd8
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } md_state_e;

  function automatic logic is_start_op(logic [3:0] op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational multiply/divide datapath producing the 64-bit {hi, lo} result.
// Division by zero yields a don't-care value; the controller suppresses its commit.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic [63:0] smul;
  logic [63:0] umul;
  logic [31:0] b_sdiv;
  logic [31:0] b_udiv;
  logic [31:0] squot;
  logic [31:0] srem;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic        s_ovf;

  assign smul = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign umul = {32'd0, a_i} * {32'd0, b_i};

  // Dividing 0x80000000 by 1 instead of -1 gives exactly the required quotient/remainder,
  // and a divisor of 1 keeps the zero-divisor case well defined.
  assign s_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign b_sdiv = ((b_i == 32'd0) || s_ovf) ? 32'd1 : b_i;
  assign b_udiv = (b_i == 32'd0) ? 32'd1 : b_i;

  assign squot = $signed(a_i) / $signed(b_sdiv);
  assign srem  = $signed(a_i) % $signed(b_sdiv);
  assign uquot = a_i / b_udiv;
  assign urem  = a_i % b_udiv;

  always_comb begin
    res_o = '0;
    case (op_i)
      MdMult:  res_o = smul;
      MdMultu: res_o = umul;
      MdDiv:   res_o = {srem, squot};
      MdDivu:  res_o = {urem, uquot};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide controller: owns HI/LO, stages the result in hi_tmp/lo_tmp
// and commits it after the configured busy window.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_valid,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  output logic        E_HILObusy,
  output logic [31:0] E_MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     hi_tmp_q, hi_tmp_d;
  logic [31:0]     lo_tmp_q, lo_tmp_d;
  logic            div0_q, div0_d;
  logic            start;
  logic            is_div;
  logic [63:0]     calc_res;

  md_calc u_calc (
    .op_i  (E_MDOp),
    .a_i   (E_rs_val),
    .b_i   (E_rt_val),
    .res_o (calc_res)
  );

  assign is_div     = is_div_op(E_MDOp);
  assign start      = E_valid && (state_q == StIdle) && is_start_op(E_MDOp);
  assign E_HILObusy = start || (state_q == StBusy);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    div0_d   = div0_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StBusy;
          hi_tmp_d = calc_res[63:32];
          lo_tmp_d = calc_res[31:0];
          count_d  = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          div0_d   = is_div && (E_rt_val == 32'd0);
        end else if (E_valid) begin
          if (E_MDOp == MdMthi) hi_d = E_rs_val;
          if (E_MDOp == MdMtlo) lo_d = E_rs_val;
        end
      end
      StBusy: begin
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          state_d = StIdle;
          if (!div0_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    E_MDOut = 32'd0;
    if (E_MDOp == MdMfhi) E_MDOut = hi_q;
    if (E_MDOp == MdMflo) E_MDOut = lo_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      div0_q   <= div0_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: busy window length, commit timing, arithmetic corner cases,
// HI/LO moves, ignored ops and reset abort.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        E_valid;
  logic [3:0]  E_MDOp;
  logic [31:0] E_rs_val;
  logic [31:0] E_rt_val;
  logic        E_HILObusy;
  logic [31:0] E_MDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .E_valid    (E_valid),
    .E_MDOp     (E_MDOp),
    .E_rs_val   (E_rs_val),
    .E_rt_val   (E_rt_val),
    .E_HILObusy (E_HILObusy),
    .E_MDOut    (E_MDOut),
    .HI         (HI),
    .LO         (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    E_valid  = 1'b0;
    E_MDOp   = MdNone;
    E_rs_val = 32'd0;
    E_rt_val = 32'd0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    E_valid  = 1'b1;
    E_MDOp   = op;
    E_rs_val = rs;
    E_rt_val = rt;
  endtask

  // Issues op in cycle 0 and watches 20 cycles; n is the busy count after the start cycle.
  task automatic run_start(input string tag, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input int n,
                           input logic [31:0] hi_pre, input logic [31:0] lo_pre,
                           input logic [31:0] hi_exp, input logic [31:0] lo_exp,
                           input bit inject);
    int busy_cnt;
    int drop;
    busy_cnt = 0;
    drop     = -1;
    issue(op, rs, rt);
    #1;
    for (int c = 0; c < 20; c++) begin
      if (E_HILObusy) busy_cnt++;
      else if (drop < 0) drop = c;
      if (c == n) begin
        check({tag, "_hi_pre"}, HI, hi_pre);
        check({tag, "_lo_pre"}, LO, lo_pre);
      end
      if (c == n + 1) begin
        check({tag, "_hi"}, HI, hi_exp);
        check({tag, "_lo"}, LO, lo_exp);
      end
      tick();
      if (inject && c == 1) issue(MdMult, 32'd2, 32'd3);
      else idle_in();
      #1;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n + 1));
    check({tag, "_busy_drop"}, 32'(drop), 32'(n + 1));
  endtask

  initial begin
    int busy_seen;
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(E_HILObusy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    E_MDOp = MdMfhi;
    #1;
    check("rst_mdout", E_MDOut, 32'd0);
    idle_in();
    tick();

    run_start("mult", MdMult, 32'hFFFF_FFFD, 32'd5, 5,
              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_start("divu", MdDivu, 32'd7, 32'd2, 10,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'd1, 32'd3, 1'b0);
    run_start("div", MdDiv, 32'hFFFF_FFF9, 32'd2, 10,
              32'd1, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_start("multu", MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    // Preset HI/LO through the move ops, then divide by zero must leave them alone.
    issue(MdMthi, 32'h11, 32'd0);
    #1;
    check("mthi_busy", 32'(E_HILObusy), 32'd0);
    tick();
    issue(MdMtlo, 32'h22, 32'd0);
    #1;
    check("mtlo_busy", 32'(E_HILObusy), 32'd0);
    tick();
    issue(MdMflo, 32'd0, 32'd0);
    #1;
    check("mflo_data", E_MDOut, 32'h22);
    idle_in();
    tick();
    run_start("div0", MdDiv, 32'd5, 32'd0, 10,
              32'h11, 32'h22, 32'h11, 32'h22, 1'b0);

    issue(MdMthi, 32'hDEAD_BEEF, 32'd0);
    #1;
    busy_seen = int'(E_HILObusy);
    tick();
    issue(MdMfhi, 32'd0, 32'd0);
    #1;
    busy_seen += int'(E_HILObusy);
    check("mfhi_data", E_MDOut, 32'hDEAD_BEEF);
    check("mthi_mfhi_busy", 32'(busy_seen), 32'd0);

    // An op with E_valid low must be ignored completely.
    E_valid  = 1'b0;
    E_MDOp   = MdMult;
    E_rs_val = 32'd2;
    E_rt_val = 32'd3;
    #1;
    busy_seen = int'(E_HILObusy);
    check("inval_mdout", E_MDOut, 32'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      busy_seen += int'(E_HILObusy);
    end
    check("inval_busy", 32'(busy_seen), 32'd0);
    check("inval_hi", HI, 32'hDEAD_BEEF);
    check("inval_lo", LO, 32'h22);
    idle_in();
    tick();

    run_start("mult_inject", MdMult, 32'h0001_0000, 32'h0001_0000, 5,
              32'hDEAD_BEEF, 32'h22, 32'd1, 32'd0, 1'b1);
    run_start("div_ovf", MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 10,
              32'd1, 32'd0, 32'd0, 32'h8000_0000, 1'b0);

    // Reset in cycle 3 of a divu aborts it with nothing committed.
    issue(MdMthi, 32'h55, 32'd0);
    tick();
    issue(MdDivu, 32'd100, 32'd7);
    #1;
    tick();
    idle_in();
    tick();
    tick();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(E_HILObusy), 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    busy_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      busy_seen += int'(E_HILObusy);
    end
    check("rst_mid_busy_later", 32'(busy_seen), 32'd0);
    check("rst_mid_hi_later", HI, 32'd0);
    check("rst_mid_lo_later", LO, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide controller in stage E.
- Executes mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
- Owns the HI/LO registers and schedules their update latency.
- Drives E_HILObusy into the stall unit, which holds HI/LO instructions in D while the unit is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after the start cycle for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles after the start cycle for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; one clock; all state updates on rising edge of clk
- E_valid  input  1  E-stage instruction is real (0 on bubbles/flushed slots)
- E_MDOp  input  4  operation code (`MD_* constants)
- E_rs_val  input  32  forwarded rs operand
- E_rt_val  input  32  forwarded rt operand
- E_HILObusy  output  1  unit busy or starting this cycle
- E_MDOut  output  32  mfhi/mflo read data, combinational
- HI  output  32  committed HI register
- LO  output  32  committed LO register

Behaviour:
- Reset (sync, active-high): state=IDLE, count=0, HI=0, LO=0, hi_tmp=0, lo_tmp=0, div0=0. Outputs after reset: E_HILObusy=0, E_MDOut=0.
- start = E_valid & (state==IDLE) & E_MDOp in {MULT, MULTU, DIV, DIVU}.
- E_HILObusy = start | (state==BUSY), combinational, so the stall unit sees it in the start cycle.
- States: IDLE, BUSY.
- IDLE -> BUSY on start:
  - latch the full 64-bit result into hi_tmp/lo_tmp;
  - load count with MULT_CYCLES or DIV_CYCLES;
  - latch div0 = (div op & E_rt_val==0).
- In BUSY:
  - count decrements each cycle;
  - when count==1 the edge commits HI<=hi_tmp and LO<=lo_tmp (skipped if div0), then state->IDLE.
- Latency: start in cycle 0 gives busy in cycles 0..N (N+1 cycles). HI/LO are updated at the edge ending cycle N. An mfhi in cycle N+1 reads the new value.
- Arithmetic:
  - mult: signed 32x32->64, HI=[63:32], LO=[31:0].
  - multu: unsigned.
  - div: signed, LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned.
  - 0x80000000 / -1: LO=0x80000000, HI=0.
- Divide by zero: HI/LO are left unchanged, but the full busy duration still applies.
- mthi/mtlo:
  - write HI/LO from E_rs_val at the next edge when E_valid & state==IDLE; no busy asserted.
  - In BUSY they are ignored; the stall unit guarantees they are not issued then.
- mfhi/mflo: E_MDOut = HI or LO as currently committed. Other ops: E_MDOut=0.
- A start op presented while BUSY is ignored; it does not restart or extend count.
- E_valid=0: the op is ignored entirely.
- Reset mid-operation: abort immediately, nothing commits, and all state returns to reset values on that edge.
- Reset and start in the same cycle: reset wins.

Decomposition:
- The shared const.v holds the `MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8 codes and the state encodings. The decoder (_CU) produces E_MDOp from those same constants.
- One sub-module, md_calc: purely combinational. It takes op, a and b and produces the 64-bit {hi,lo} result; it isolates the signed/unsigned and div-by-zero/overflow rules.
- md_unit keeps the FSM, the counter and the HI/LO registers.

Test Plan:
- mult rs=0xFFFFFFFD (-3), rt=5 -> E_HILObusy=1 for exactly 6 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1 visible in cycle 6, unchanged before.
- divu 7/2 then div -7/2 -> first: after 11 busy cycles LO=3, HI=1; second: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 5/0 with HI=0x11, LO=0x22 preset via mthi/mtlo -> busy 11 cycles, HI/LO remain 0x11/0x22.
- mthi 0xDEADBEEF in idle, mfhi next cycle -> E_MDOut=0xDEADBEEF, E_HILObusy never asserted; mult presented with E_valid=0 -> no busy, HI/LO unchanged.
- mult started, second mult 0x2*0x3 presented in cycle 2 -> ignored; the first result commits in cycle 6 and busy drops in cycle 6.
- reset asserted in cycle 3 of a divu -> cycle 4 E_HILObusy=0, HI=LO=0, no later commit.
